// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - 16x16 unsigned shift-and-add multiplier built around one rca16 ripple-carry adder

module rca16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        c
);
    logic [16:0] cy;

    assign cy[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign s[i]    = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign c = cy[16];
endmodule

module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    if (WIDTH != 16) begin : g_bad_width
        $error("mul16_seq: only WIDTH=16 is supported (rca16 is fixed at 16 bits)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  cnt;

    logic [15:0] add_b;
    logic [15:0] sum;
    logic        carry;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b = lo[0] ? mcand : 16'h0000;

    rca16 u_add (
        .a (hi),
        .b (add_b),
        .s (sum),
        .c (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= 16'h0000;
            hi      <= 16'h0000;
            lo      <= 16'h0000;
            cnt     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a[15:0];
                        lo    <= b[15:0];
                        hi    <= 16'h0000;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Carry-out becomes the top bit of hi, so no product bit is lost.
                    hi  <= {carry, sum[15:1]};
                    lo  <= {sum[0], lo[15:1]};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        product <= {carry, sum[15:1], sum[0], lo[15:1]};
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
